// File: rtl/piano_pkg.sv
// Shared definitions for the autoplay song sequencer.
// Contents: FSM state encoding, bit positions of the fields in a ROM song
// entry, the entry width, and the tempo_sel codes.
// No ports; import with "import piano_pkg::*;".
package piano_pkg;

    // Song entry layout: [9]=end marker, [8]=rest, [7:4]=note, [3:0]=dur
    localparam int ENTRY_W  = 10;
    localparam int END_BIT  = 9;
    localparam int REST_BIT = 8;
    localparam int NOTE_MSB = 7;
    localparam int NOTE_LSB = 4;
    localparam int DUR_MSB  = 3;
    localparam int DUR_LSB  = 0;

    // tempo_sel codes; code 3 falls back to normal tempo
    localparam logic [1:0] TEMPO_NORMAL = 2'd0;
    localparam logic [1:0] TEMPO_FAST   = 2'd1;
    localparam logic [1:0] TEMPO_SLOW   = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_NOTE,
        ST_GAP,
        ST_DONE
    } state_t;

endpackage

// File: rtl/song_sequencer_if.sv
// ROM read bus between the song sequencer and the external synchronous
// note ROM.
//   rom_addr : ADDR_W  read address, driven by the sequencer (master)
//   rom_data : ENTRY_W entry, driven by the ROM (slave) one cycle after rom_addr
interface song_sequencer_if #(
    parameter int ADDR_W = 8
);
    import piano_pkg::*;

    logic [ADDR_W-1:0]  rom_addr;
    logic [ENTRY_W-1:0] rom_data;

    modport master (output rom_addr, input rom_data);
    modport slave  (input rom_addr, output rom_data);

endinterface

// File: rtl/song_sequencer_note_timer.sv
// note_timer: loadable down-counter shared by the NOTE and GAP intervals.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load value into the counter (wins over counting)
//   value      : interval length in cycles; the interval lasts exactly
//                this many enabled cycles
//   enable     : count this cycle (low while paused)
//   expire     : single-cycle flag during the last enabled cycle
module note_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] value,
    input  logic         enable,
    output logic         expire
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (enable && count != '0) begin
            count <= count - W'(1);
        end
    end

    // Expiring on count==1 lets the owner reload in the same edge,
    // so back-to-back intervals have no dead cycle between them.
    assign expire = enable && (count == W'(1));

endmodule

// File: rtl/song_sequencer.sv
// song_sequencer: autoplay melody engine. Walks a song stored in an external
// synchronous ROM, plays each note for (dur+1) beats minus a short silent
// articulation gap, and drives the LED/tone stage.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   start          : pulse, begin playback at address 0 (ignored while busy)
//   stop           : pulse, abort playback (beats start and pause)
//   pause          : level, freeze playback while high
//   tempo_sel[1:0] : 0/3 normal, 1 fast (half beat), 2 slow (double beat)
//   rom            : ROM read bus (master modport)
//   current_track  : note index being played
//   playing        : high while a non-rest note sounds
//   busy           : high in every state except IDLE
//   song_done      : one-cycle pulse at the natural end of the song
// Build option: define SONG_SEQUENCER_LOOP_EN to restart from address 0 at
// the end of the song instead of returning to IDLE.
module song_sequencer
    import piano_pkg::*;
#(
    parameter int BEAT_CYCLES = 25_000_000,
    parameter int GAP_CYCLES  = 1_000_000,
    parameter int ADDR_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic [1:0]       tempo_sel,
    song_sequencer_if.master rom,
    output logic [3:0]       current_track,
    output logic             playing,
    output logic             busy,
    output logic             song_done
);

    // Wide enough for 16 beats at the slow (doubled) tempo
    localparam int CNT_W = $clog2(32 * BEAT_CYCLES + 1);

    state_t            state, state_next;
    logic [ADDR_W-1:0] rom_addr_q, addr_next;
    logic [3:0]        track_next;
    logic              rest_q, rest_next;
    logic              playing_next, busy_next, done_next;
    logic              tmr_load, tmr_expire;
    logic [CNT_W-1:0]  tmr_value;
    logic [CNT_W-1:0]  beat_len, note_len;

    assign rom.rom_addr = rom_addr_q;

    // tempo_sel only matters when a note is decoded
    always_comb begin
        case (tempo_sel)
            TEMPO_FAST: beat_len = CNT_W'(BEAT_CYCLES / 2);
            TEMPO_SLOW: beat_len = CNT_W'(BEAT_CYCLES * 2);
            default:    beat_len = CNT_W'(BEAT_CYCLES);
        endcase
        note_len = (CNT_W'(rom.rom_data[DUR_MSB:DUR_LSB]) + CNT_W'(1)) * beat_len
                   - CNT_W'(GAP_CYCLES);
    end

    note_timer #(.W(CNT_W)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (tmr_load),
        .value  (tmr_value),
        .enable (!pause),
        .expire (tmr_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            rom_addr_q    <= '0;
            current_track <= '0;
            rest_q        <= 1'b0;
            playing       <= 1'b0;
            busy          <= 1'b0;
            song_done     <= 1'b0;
        end else begin
            state         <= state_next;
            rom_addr_q    <= addr_next;
            current_track <= track_next;
            rest_q        <= rest_next;
            playing       <= playing_next;
            busy          <= busy_next;
            song_done     <= done_next;
        end
    end

    // Next-state and next-output logic. Outputs are computed for the state
    // being entered so that the registered outputs line up with the state.
    // The timer only advances while pause is low, so a paused NOTE or GAP
    // resumes with exactly the cycles it had left.
    always_comb begin
        state_next   = state;
        addr_next    = rom_addr_q;
        track_next   = current_track;
        rest_next    = rest_q;
        playing_next = 1'b0;
        done_next    = 1'b0;
        tmr_load     = 1'b0;
        tmr_value    = '0;

        if (stop && state != ST_IDLE) begin
            state_next = ST_IDLE;
            tmr_load   = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state_next = ST_FETCH;
                        addr_next  = '0;
                    end
                end
                ST_FETCH: begin
                    if (!pause) state_next = ST_DECODE;
                end
                ST_DECODE: begin
                    if (!pause) begin
                        if (rom.rom_data[END_BIT]) begin
                            done_next = 1'b1;
`ifdef SONG_SEQUENCER_LOOP_EN
                            addr_next  = '0;
                            state_next = ST_FETCH;
`else
                            state_next = ST_DONE;
`endif
                        end else begin
                            track_next   = rom.rom_data[NOTE_MSB:NOTE_LSB];
                            rest_next    = rom.rom_data[REST_BIT];
                            playing_next = !rom.rom_data[REST_BIT];
                            tmr_load     = 1'b1;
                            tmr_value    = note_len;
                            state_next   = ST_NOTE;
                        end
                    end
                end
                ST_NOTE: begin
                    if (tmr_expire) begin
                        state_next = ST_GAP;
                        tmr_load   = 1'b1;
                        tmr_value  = CNT_W'(GAP_CYCLES);
                    end else if (!pause) begin
                        playing_next = !rest_q;
                    end
                end
                ST_GAP: begin
                    if (tmr_expire) begin
                        // Last ROM address acts as an implicit end marker
                        if (&rom_addr_q) begin
                            done_next = 1'b1;
`ifdef SONG_SEQUENCER_LOOP_EN
                            addr_next  = '0;
                            state_next = ST_FETCH;
`else
                            state_next = ST_DONE;
`endif
                        end else begin
                            addr_next  = rom_addr_q + ADDR_W'(1);
                            state_next = ST_FETCH;
                        end
                    end
                end
                ST_DONE: begin
                    state_next = ST_IDLE;
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end

        busy_next = (state_next != ST_IDLE);
    end

endmodule

// File: tb/tb_song_sequencer.sv
// Self-checking bench for song_sequencer with BEAT_CYCLES=8, GAP_CYCLES=2.
// A table of single-note songs covers tempo and duration combinations;
// hand-written sequences cover rests, pause, stop/restart, end of ROM,
// asynchronous reset and (with SONG_SEQUENCER_LOOP_EN) looping.
module tb_song_sequencer;

    localparam int BEAT   = 8;
    localparam int GAP    = 2;
    localparam int ADDR_W = 8;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic       pause;
    logic [1:0] tempo_sel;
    logic [3:0] current_track;
    logic       playing;
    logic       busy;
    logic       song_done;

    int assertions;
    int failures;

    logic [9:0] rom_mem [0:255];

    song_sequencer_if #(.ADDR_W(ADDR_W)) rom_if ();

    song_sequencer #(
        .BEAT_CYCLES (BEAT),
        .GAP_CYCLES  (GAP),
        .ADDR_W      (ADDR_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .stop          (stop),
        .pause         (pause),
        .tempo_sel     (tempo_sel),
        .rom           (rom_if),
        .current_track (current_track),
        .playing       (playing),
        .busy          (busy),
        .song_done     (song_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM: data valid one cycle after the address
    always @(posedge clk) rom_if.rom_data <= rom_mem[rom_if.rom_addr];

    typedef struct {
        logic [1:0] tempo;
        logic [1:0] tempo_mid;
        logic [3:0] note;
        logic       rest;
        logic [3:0] dur;
        int         len;
    } vec_t;

    vec_t vecs [8];

    function automatic logic [9:0] make_entry(input logic e, input logic r,
                                              input logic [3:0] n, input logic [3:0] d);
        return {e, r, n, d};
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom_mem[i] = 10'h200;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Checks `cycles` consecutive cycles against one expected output set;
    // one comparison per segment.
    task automatic check_output(input string tname, input int seg, input int cycles,
                                input logic e_play, input logic [3:0] e_track,
                                input logic chk_track, input logic e_busy,
                                input logic e_done);
        int bad;
        logic a_play, a_busy, a_done;
        logic [3:0] a_track;
        bad = 0;
        a_play = 1'b0; a_busy = 1'b0; a_done = 1'b0; a_track = 4'd0;
        for (int c = 0; c < cycles; c++) begin
            if (playing !== e_play || busy !== e_busy || song_done !== e_done ||
                (chk_track && current_track !== e_track)) begin
                if (bad == 0) begin
                    a_play = playing; a_busy = busy; a_done = song_done; a_track = current_track;
                end
                bad++;
            end
            step();
        end
        assertions++;
        if (bad != 0) begin
            failures++;
            $display("[TB] FAIL %s seg %0d: got play=%b track=%0d busy=%b done=%b, required play=%b track=%0d busy=%b done=%b (%0d of %0d cycles wrong)",
                     tname, seg, a_play, a_track, a_busy, a_done,
                     e_play, e_track, e_busy, e_done, bad, cycles);
        end
    endtask

    task automatic check_addr(input string tname, input logic [ADDR_W-1:0] e_addr);
        assertions++;
        if (rom_if.rom_addr !== e_addr) begin
            failures++;
            $display("[TB] FAIL %s rom_addr: got %0d, required %0d", tname, rom_if.rom_addr, e_addr);
        end
    endtask

    task automatic check_idle_outputs(input string tname);
        assertions++;
        if (rom_if.rom_addr !== '0 || current_track !== 4'd0 || playing !== 1'b0 ||
            busy !== 1'b0 || song_done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL %s: got addr=%0d track=%0d play=%b busy=%b done=%b, required all zero",
                     tname, rom_if.rom_addr, current_track, playing, busy, song_done);
        end
    endtask

    // Plays one single-note song from the table and checks every phase
    task automatic apply_stimulus(input int i);
        clear_rom();
        rom_mem[0] = make_entry(1'b0, vecs[i].rest, vecs[i].note, vecs[i].dur);
        tempo_sel = vecs[i].tempo;
        pulse_start();
        check_output($sformatf("row%0d", i), 0, 2, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        tempo_sel = vecs[i].tempo_mid;
        check_output($sformatf("row%0d", i), 1, vecs[i].len, !vecs[i].rest, vecs[i].note, 1'b1, 1'b1, 1'b0);
        check_output($sformatf("row%0d", i), 2, GAP, 1'b0, vecs[i].note, 1'b1, 1'b1, 1'b0);
        check_output($sformatf("row%0d", i), 3, 2, 1'b0, vecs[i].note, 1'b1, 1'b1, 1'b0);
        check_output($sformatf("row%0d", i), 4, 1, 1'b0, vecs[i].note, 1'b1, 1'b1, 1'b1);
        check_output($sformatf("row%0d", i), 5, 1, 1'b0, vecs[i].note, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        assertions = 0;
        failures   = 0;
        rst_n      = 1'b0;
        start      = 1'b0;
        stop       = 1'b0;
        pause      = 1'b0;
        tempo_sel  = 2'd0;
        clear_rom();

        // {tempo, tempo after decode, note, rest, dur, NOTE cycles}
        vecs[0] = '{2'd0, 2'd0, 4'd5,  1'b0, 4'd1,  14};
        vecs[1] = '{2'd1, 2'd1, 4'd2,  1'b0, 4'd0,  2};
        vecs[2] = '{2'd2, 2'd2, 4'd11, 1'b0, 4'd0,  14};
        vecs[3] = '{2'd3, 2'd3, 4'd0,  1'b0, 4'd0,  6};
        vecs[4] = '{2'd2, 2'd1, 4'd13, 1'b0, 4'd0,  14};
        vecs[5] = '{2'd0, 2'd0, 4'd15, 1'b0, 4'd15, 126};
        vecs[6] = '{2'd1, 2'd1, 4'd3,  1'b1, 4'd2,  10};
        vecs[7] = '{2'd0, 2'd2, 4'd8,  1'b0, 4'd0,  6};

        #22;
        check_idle_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check_idle_outputs("after reset release");

`ifndef SONG_SEQUENCER_LOOP_EN
        for (int i = 0; i < 8; i++) apply_stimulus(i);

        // Rest followed by a sounding note
        clear_rom();
        rom_mem[0] = make_entry(1'b0, 1'b1, 4'd3, 4'd0);
        rom_mem[1] = make_entry(1'b0, 1'b0, 4'd7, 4'd0);
        tempo_sel = 2'd0;
        pulse_start();
        check_output("rest", 0, 2, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        check_output("rest", 1, 8, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0);
        check_addr("rest second fetch", 8'd1);
        check_output("rest", 2, 2, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0);
        check_output("rest", 3, 6, 1'b1, 4'd7, 1'b1, 1'b1, 1'b0);
        check_output("rest", 4, 4, 1'b0, 4'd7, 1'b1, 1'b1, 1'b0);
        check_output("rest", 5, 1, 1'b0, 4'd7, 1'b1, 1'b1, 1'b1);
        check_output("rest", 6, 1, 1'b0, 4'd7, 1'b1, 1'b0, 1'b0);

        // 5-cycle pause inside a 6-cycle note: 11 NOTE cycles in total
        clear_rom();
        rom_mem[0] = make_entry(1'b0, 1'b0, 4'd9, 4'd0);
        pulse_start();
        check_output("pause", 0, 2, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        check_output("pause", 1, 2, 1'b1, 4'd9, 1'b1, 1'b1, 1'b0);
        pause = 1'b1;
        check_output("pause", 2, 1, 1'b1, 4'd9, 1'b1, 1'b1, 1'b0);
        check_output("pause", 3, 4, 1'b0, 4'd9, 1'b1, 1'b1, 1'b0);
        pause = 1'b0;
        check_output("pause", 4, 1, 1'b0, 4'd9, 1'b1, 1'b1, 1'b0);
        check_output("pause", 5, 3, 1'b1, 4'd9, 1'b1, 1'b1, 1'b0);
        check_output("pause", 6, 4, 1'b0, 4'd9, 1'b1, 1'b1, 1'b0);
        check_output("pause", 7, 1, 1'b0, 4'd9, 1'b1, 1'b1, 1'b1);

        // Stop in the second note, then replay from address 0 (start while busy ignored)
        clear_rom();
        rom_mem[0] = make_entry(1'b0, 1'b0, 4'd4, 4'd0);
        rom_mem[1] = make_entry(1'b0, 1'b0, 4'd6, 4'd1);
        pulse_start();
        check_output("stop", 0, 2, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        check_output("stop", 1, 6, 1'b1, 4'd4, 1'b1, 1'b1, 1'b0);
        check_output("stop", 2, 4, 1'b0, 4'd4, 1'b1, 1'b1, 1'b0);
        check_output("stop", 3, 2, 1'b1, 4'd6, 1'b1, 1'b1, 1'b0);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check_output("stop", 4, 4, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        pulse_start();
        check_addr("restart fetch", 8'd0);
        check_output("restart", 0, 2, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        check_output("restart", 1, 3, 1'b1, 4'd4, 1'b1, 1'b1, 1'b0);
        start = 1'b1;
        check_output("restart", 2, 1, 1'b1, 4'd4, 1'b1, 1'b1, 1'b0);
        start = 1'b0;
        check_output("restart", 3, 2, 1'b1, 4'd4, 1'b1, 1'b1, 1'b0);
        check_output("restart", 4, 4, 1'b0, 4'd4, 1'b1, 1'b1, 1'b0);
        check_output("restart", 5, 14, 1'b1, 4'd6, 1'b1, 1'b1, 1'b0);
        check_output("restart", 6, 4, 1'b0, 4'd6, 1'b1, 1'b1, 1'b0);
        check_output("restart", 7, 1, 1'b0, 4'd6, 1'b1, 1'b1, 1'b1);
        check_output("restart", 8, 1, 1'b0, 4'd6, 1'b1, 1'b0, 1'b0);

        // Full ROM without end marker at fast tempo: 6 cycles per entry
        for (int i = 0; i < 256; i++) rom_mem[i] = make_entry(1'b0, 1'b0, 4'(i), 4'd0);
        tempo_sel = 2'd1;
        pulse_start();
        n = 0;
        while (song_done !== 1'b1 && n < 3000) begin
            step();
            n++;
        end
        assertions++;
        if (n != 1536) begin
            failures++;
            $display("[TB] FAIL end of ROM: song_done after %0d cycles, required 1536", n);
        end
        check_addr("end of ROM", 8'd255);
        step();
        check_output("end of ROM idle", 0, 1, 1'b0, 4'd15, 1'b1, 1'b0, 1'b0);
        tempo_sel = 2'd0;
`else
        // Looping playback of a one-note song
        clear_rom();
        rom_mem[0] = make_entry(1'b0, 1'b0, 4'd1, 4'd0);
        pulse_start();
        check_output("loop", 0, 2, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        for (int p = 0; p < 2; p++) begin
            check_output("loop", 10 * p + 1, 6, 1'b1, 4'd1, 1'b1, 1'b1, 1'b0);
            check_output("loop", 10 * p + 2, 2, 1'b0, 4'd1, 1'b1, 1'b1, 1'b0);
            check_addr("loop end fetch", 8'd1);
            check_output("loop", 10 * p + 3, 2, 1'b0, 4'd1, 1'b1, 1'b1, 1'b0);
            check_addr("loop wrap", 8'd0);
            check_output("loop", 10 * p + 4, 1, 1'b0, 4'd1, 1'b1, 1'b1, 1'b1);
            check_output("loop", 10 * p + 5, 1, 1'b0, 4'd1, 1'b1, 1'b1, 1'b0);
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        check_output("loop stop", 0, 3, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
`endif

        // Asynchronous reset in the middle of a note
        clear_rom();
        rom_mem[0] = make_entry(1'b0, 1'b0, 4'd12, 4'd3);
        pulse_start();
        check_output("async reset", 0, 2, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        check_output("async reset", 1, 3, 1'b1, 4'd12, 1'b1, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("async reset");
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check_output("post reset", 0, 2, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
